// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: FIFO controller over a single-port 1-cycle-latency SRAM with a 2-entry output buffer
package fifo_package;
    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 2;
    localparam int DEPTH      = 4;
endpackage

module sram_fifo_ctrl #(
    parameter int DATA_WIDTH = fifo_package::DATA_WIDTH,
    parameter int ADDR_WIDTH = fifo_package::ADDR_WIDTH,
    parameter int DEPTH      = fifo_package::DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_valid_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    output logic                  push_ready_o,
    output logic                  pop_valid_o,
    output logic [DATA_WIDTH-1:0] pop_data_o,
    input  logic                  pop_ready_i,
    output logic [ADDR_WIDTH-1:0] sram_addr_o,
    output logic [DATA_WIDTH-1:0] sram_wdata_o,
    output logic                  sram_we_o,
    input  logic [DATA_WIDTH-1:0] sram_rdata_i,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  full_o,
    output logic                  empty_o
);
    typedef enum logic {WRITE = 1'b0, READ = 1'b1} rr_t;

    localparam logic [ADDR_WIDTH-1:0] LAST   = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   FULL_N = (ADDR_WIDTH + 1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [ADDR_WIDTH:0]   mem_count, mem_count_nxt, count_nxt, count_r;
    logic                  rd_pending, full_r, empty_r;
    logic [1:0]            obuf_count, obuf_count_nxt, obuf_kept;
    logic [DATA_WIDTH-1:0] obuf [2];
    logic                  cap_slot;
    rr_t                   rr;
    logic                  not_full, pop_fire, read_req, read_first;
    logic                  push_fire, read_grant, contention;
    logic [2:0]            occ;

    assign pop_valid_o  = obuf_count != 2'd0;
    assign pop_data_o   = obuf[0];
    assign sram_we_o    = push_fire;
    assign sram_addr_o  = push_fire ? wr_ptr : rd_ptr;
    assign sram_wdata_o = push_data_i;
    assign count_o      = count_r;
    assign full_o       = full_r;
    assign empty_o      = empty_r;

    // arbitrate the single SRAM port: a prefetch read wins only when rr points at READ or no push fires
    always_comb begin
        not_full       = mem_count < FULL_N;
        pop_fire       = pop_valid_o && pop_ready_i;
        occ            = 3'(obuf_count) + 3'(rd_pending) - 3'(pop_fire);
        read_req       = (mem_count != '0) && (occ < 3'd2);
        read_first     = read_req && (rr == READ);
        push_ready_o   = !read_first && not_full;
        push_fire      = push_valid_i && push_ready_o;
        read_grant     = read_req && (read_first || !push_fire);
        contention     = read_req && push_valid_i && not_full;
        mem_count_nxt  = mem_count + (ADDR_WIDTH + 1)'(push_fire) - (ADDR_WIDTH + 1)'(read_grant);
        obuf_count_nxt = obuf_count + 2'(rd_pending) - 2'(pop_fire);
        obuf_kept      = obuf_count - 2'(pop_fire);
        cap_slot       = obuf_kept[0];
        count_nxt      = mem_count_nxt + (ADDR_WIDTH + 1)'(read_grant) + (ADDR_WIDTH + 1)'(obuf_count_nxt);
    end

    // pointers, occupancy, in-flight read flag, round-robin winner and registered flags
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            mem_count  <= '0;
            rd_pending <= 1'b0;
            obuf_count <= 2'd0;
            rr         <= WRITE;
            count_r    <= '0;
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
        end else begin
            if (push_fire)
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            if (read_grant)
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            if (contention)
                rr <= read_grant ? WRITE : READ;
            mem_count  <= mem_count_nxt;
            rd_pending <= read_grant;
            obuf_count <= obuf_count_nxt;
            count_r    <= count_nxt;
            full_r     <= mem_count_nxt == FULL_N;
            empty_r    <= count_nxt == '0;
        end
    end

    // output buffer: shift on pop, then land returning read data in the first free slot
    always_ff @(posedge clk) begin
        if (rst) begin
            obuf[0] <= '0;
            obuf[1] <= '0;
        end else begin
            if (pop_fire)
                obuf[0] <= obuf[1];
            if (rd_pending)
                obuf[cap_slot] <= sram_rdata_i;
        end
    end

    // read requests are throttled so the 2-entry buffer can never overflow
    always_ff @(posedge clk) begin
        if (!rst)
            assert (obuf_count <= 2'd2);
    end
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb_sram_fifo_ctrl: vector tables, corner sequences and randomized streams against a queue model
module tb_sram_fifo_ctrl;
    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          push_valid_i, push_ready_o, pop_valid_o, pop_ready_i;
    logic [DW-1:0] push_data_i, pop_data_o, sram_wdata_o, sram_rdata_i;
    logic [AW-1:0] sram_addr_o;
    logic          sram_we_o, full_o, empty_o;
    logic [AW:0]   count_o;
    logic [DW-1:0] sram_mem [DEPTH];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          pv;
        logic [DW-1:0] pd;
        logic          pr;
        logic          e_prdy;
        logic          e_pval;
        logic [DW-1:0] e_pdat;
        logic [AW:0]   e_cnt;
        logic          e_full;
        logic          e_empty;
    } vec_t;

    sram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .push_valid_i(push_valid_i), .push_data_i(push_data_i), .push_ready_o(push_ready_o),
        .pop_valid_o(pop_valid_o), .pop_data_o(pop_data_o), .pop_ready_i(pop_ready_i),
        .sram_addr_o(sram_addr_o), .sram_wdata_o(sram_wdata_o), .sram_we_o(sram_we_o),
        .sram_rdata_i(sram_rdata_i), .count_o(count_o), .full_o(full_o), .empty_o(empty_o)
    );

    always #5 clk = ~clk;

    // single-port SRAM with 1-cycle read latency
    always @(posedge clk) begin
        if (sram_we_o) sram_mem[sram_addr_o] <= sram_wdata_o;
        sram_rdata_i <= sram_mem[sram_addr_o];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic pv, input logic [7:0] pd, input logic pr, input logic e_prdy,
                                input logic e_pval, input logic [7:0] e_pdat, input logic [2:0] e_cnt,
                                input logic e_full, input logic e_empty);
        vec_t v;
        v.pv = pv; v.pd = pd; v.pr = pr; v.e_prdy = e_prdy; v.e_pval = e_pval;
        v.e_pdat = e_pdat; v.e_cnt = e_cnt; v.e_full = e_full; v.e_empty = e_empty;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; push_valid_i = 1'b0; pop_ready_i = 1'b0; push_data_i = '0;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    task automatic run_table(input string tag, input vec_t tbl[$]);
        foreach (tbl[i]) begin
            push_valid_i = tbl[i].pv; push_data_i = tbl[i].pd; pop_ready_i = tbl[i].pr;
            @(negedge clk);
            chk($sformatf("%s row %0d", tag, i),
                {push_ready_o, pop_valid_o, tbl[i].e_pval ? pop_data_o : 8'h00, count_o, full_o, empty_o},
                {tbl[i].e_prdy, tbl[i].e_pval, tbl[i].e_pdat, tbl[i].e_cnt, tbl[i].e_full, tbl[i].e_empty});
            tick();
        end
    endtask

    // streams n entries under random handshakes; the model is a plain queue of accepted data
    task automatic run_stream(input string tag, input int n, input int ppush, input int ppop,
                              input bit seq, input int max_cyc, output int cycles, output int wraps);
        logic [DW-1:0] q[$];
        int sent = 0;
        int nwr = 0;
        cycles = 0;
        wraps = 0;
        while ((sent < n || q.size() > 0) && cycles < max_cyc) begin
            push_valid_i = (sent < n) && ($urandom_range(99) < ppush);
            push_data_i  = seq ? 8'(sent) : 8'($urandom);
            pop_ready_i  = $urandom_range(99) < ppop;
            @(negedge clk);
            chk({tag, " count"}, count_o, q.size());
            chk({tag, " empty"}, empty_o, q.size() == 0);
            chk({tag, " we"}, sram_we_o, push_valid_i && push_ready_o);
            if (q.size() >= DEPTH + 2) chk({tag, " ready_at_cap"}, push_ready_o, 0);
            if (sram_we_o) begin
                chk({tag, " wr_addr"}, sram_addr_o, nwr % DEPTH);
                if (int'(sram_addr_o) == DEPTH - 1) wraps++;
                nwr++;
            end
            if (pop_valid_o && pop_ready_i) begin
                if (q.size() == 0) chk({tag, " pop_when_empty"}, 1, 0);
                else chk({tag, " pop_data"}, pop_data_o, q.pop_front());
            end
            if (push_valid_i && push_ready_o) begin
                q.push_back(push_data_i);
                sent++;
            end
            tick();
            cycles++;
        end
        chk({tag, " left_over"}, (n - sent) + q.size(), 0);
        push_valid_i = 1'b0; pop_ready_i = 1'b0;
    endtask

    initial begin
        vec_t ft[$];
        vec_t fl[$];
        int got, acc, cyc, wr;
        bit seen;

        // reset values
        do_reset(2);
        @(negedge clk);
        chk("reset_outputs",
            {push_ready_o, pop_valid_o, pop_data_o, sram_we_o, sram_addr_o, count_o, full_o, empty_o},
            {1'b1, 1'b0, 8'h00, 1'b0, 2'b00, 3'd0, 1'b0, 1'b1});
        tick();

        // fall-through: push in cycle 0, visible in cycle 3 only
        ft.push_back(mk(1, 8'hA5, 1, 1, 0, 8'h00, 3'd0, 0, 1));
        ft.push_back(mk(0, 8'h00, 1, 1, 0, 8'h00, 3'd1, 0, 0));
        ft.push_back(mk(0, 8'h00, 1, 1, 0, 8'h00, 3'd1, 0, 0));
        ft.push_back(mk(0, 8'h00, 1, 1, 1, 8'hA5, 3'd1, 0, 0));
        ft.push_back(mk(0, 8'h00, 1, 1, 0, 8'h00, 3'd0, 0, 1));
        run_table("fallthrough", ft);

        // fill with the consumer stalled: 6 entries fit (4 in SRAM, 2 buffered)
        fl.push_back(mk(1, 8'h01, 0, 1, 0, 8'h00, 3'd0, 0, 1));
        fl.push_back(mk(1, 8'h02, 0, 1, 0, 8'h00, 3'd1, 0, 0));
        fl.push_back(mk(1, 8'h03, 0, 0, 0, 8'h00, 3'd2, 0, 0));
        fl.push_back(mk(1, 8'h03, 0, 1, 0, 8'h00, 3'd2, 0, 0));
        fl.push_back(mk(1, 8'h04, 0, 0, 1, 8'h01, 3'd3, 0, 0));
        fl.push_back(mk(1, 8'h04, 0, 1, 1, 8'h01, 3'd3, 0, 0));
        fl.push_back(mk(1, 8'h05, 0, 1, 1, 8'h01, 3'd4, 0, 0));
        fl.push_back(mk(1, 8'h06, 0, 1, 1, 8'h01, 3'd5, 0, 0));
        fl.push_back(mk(1, 8'h07, 0, 0, 1, 8'h01, 3'd6, 1, 0));
        run_table("fill", fl);

        // drain: 0x01..0x06 in order
        push_valid_i = 1'b0; pop_ready_i = 1'b1; got = 0;
        for (int i = 0; i < 40 && got < 6; i++) begin
            @(negedge clk);
            if (pop_valid_o) begin
                chk($sformatf("drain_data %0d", got), pop_data_o, got + 1);
                got++;
            end
            tick();
        end
        chk("drain_count", got, 6);
        @(negedge clk);
        chk("drain_empty", {empty_o, count_o}, {1'b1, 3'd0});
        tick();

        // refill, pop once so a read is in flight with count 5, then reset
        pop_ready_i = 1'b0; push_valid_i = 1'b1; acc = 0;
        for (int i = 0; i < 30 && acc < 6; i++) begin
            push_data_i = 8'h20 + 8'(acc);
            @(negedge clk);
            if (push_ready_o) acc++;
            tick();
        end
        push_valid_i = 1'b0;
        repeat (2) tick();
        pop_ready_i = 1'b1;
        tick();
        pop_ready_i = 1'b0;
        @(negedge clk);
        chk("mid_count", {count_o, pop_valid_o}, {3'd5, 1'b1});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_reset", {pop_valid_o, count_o, empty_o}, {1'b0, 3'd0, 1'b1});
        tick();
        push_valid_i = 1'b1; push_data_i = 8'h3C; pop_ready_i = 1'b1; seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (push_ready_o && push_valid_i) begin
                tick();
                push_valid_i = 1'b0;
            end else begin
                if (pop_valid_o) begin
                    chk("post_reset_first", pop_data_o, 8'h3C);
                    seen = 1'b1;
                end
                tick();
            end
        end
        chk("post_reset_seen", seen, 1);
        pop_ready_i = 1'b0;

        // saturated contention: 32 sequential values, both sides always ready
        do_reset(1);
        run_stream("sat", 32, 100, 100, 1'b1, 200, cyc, wr);
        chk("sat_cycles_bounded", cyc <= 80, 1);

        // wrap-around with random gaps
        do_reset(1);
        run_stream("wrap", 20, 60, 60, 1'b0, 400, cyc, wr);
        chk("wrap_count", wr >= 4, 1);

        // longer random soak
        do_reset(1);
        run_stream("rand", 200, 70, 50, 1'b0, 3000, cyc, wr);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
